float_conv_arbiter: RTL

Shares a single pipelined signed-int16 to IEEE-754 single-precision converter between two requesters in the thermal-camera datapath: requester 0 is the raw pixel stream and requester 1 is the ambient/calibration readout. The block arbitrates requests, tracks in-flight conversions and buffers results in an output FIFO. A result is never dropped under downstream backpressure. Each result is tagged with the requester that produced it.

---
 rtl/float_conv_pkg.sv | 29 ++
 rtl/float_conv_arbiter_if.sv | 26 ++
 rtl/int16_to_f32_pipe.sv | 61 ++++++
 rtl/float_conv_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/float_conv_pkg.sv
// Shared types and constants for the int16 -> f32 conversion arbiter.
package float_conv_pkg;

  localparam int          CONV_LATENCY = 2;
  localparam int          FLOAT_BIAS   = 127;
  localparam logic [31:0] FLOAT_ZERO   = 32'h0;
  localparam int          INFLIGHT_W   = $clog2(CONV_LATENCY + 1);

  typedef logic src_t;

  typedef struct packed {
    logic        valid;
    src_t        src;
    logic [31:0] payload;
  } conv_stage_t;

  typedef struct packed {
    src_t        src;
    logic [31:0] data;
  } fifo_entry_t;

  function automatic logic [4:0] lead_one_idx(input logic [16:0] mag);
    lead_one_idx = '0;
    for (int i = 0; i < 17; i++) begin
      if (mag[i]) lead_one_idx = 5'(i);
    end
  endfunction

endpackage

// File: rtl/float_conv_arbiter_if.sv
// Requester and result-consumer handshake bundle of float_conv_arbiter.
interface float_conv_arbiter_if;

  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, busy
  );

endinterface

// File: rtl/int16_to_f32_pipe.sv
// Two-stage exact signed-int16 to IEEE-754 single converter with valid/tag sideband.
// Stage 1: sign, magnitude, leading-one index. Stage 2: exponent and fraction.
module int16_to_f32_pipe
  import float_conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  conv_stage_t           stage_i,
  output conv_stage_t           stage_o,
  output logic [INFLIGHT_W-1:0] in_flight_o
);

  conv_stage_t s1_q, s1_d, s2_q, s2_d;

  logic        sign_s1;
  logic [16:0] ext_s1, mag_s1;
  logic        sign_s2;
  logic [4:0]  idx_s2;
  logic [16:0] mag_s2;
  logic [7:0]  exp_s2;
  logic [39:0] shifted_s2;
  logic        unused_bits;

  // 17-bit magnitude so that -32768 is representable.
  always_comb begin
    s1_d          = '0;
    sign_s1       = stage_i.payload[15];
    ext_s1        = {stage_i.payload[15], stage_i.payload[15:0]};
    mag_s1        = sign_s1 ? (~ext_s1 + 17'd1) : ext_s1;
    s1_d.valid    = stage_i.valid;
    s1_d.src      = stage_i.src;
    s1_d.payload  = {9'd0, sign_s1, lead_one_idx(mag_s1), mag_s1};
  end

  always_comb begin
    s2_d          = '0;
    sign_s2       = s1_q.payload[22];
    idx_s2        = s1_q.payload[21:17];
    mag_s2        = s1_q.payload[16:0];
    exp_s2        = 8'(FLOAT_BIAS) + {3'd0, idx_s2};
    shifted_s2    = {23'd0, mag_s2} << (5'd23 - idx_s2);
    s2_d.valid    = s1_q.valid;
    s2_d.src      = s1_q.src;
    s2_d.payload  = (mag_s2 == '0) ? FLOAT_ZERO : {sign_s2, exp_s2, shifted_s2[22:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign stage_o     = s2_q;
  assign in_flight_o = INFLIGHT_W'(s1_q.valid) + INFLIGHT_W'(s2_q.valid);
  assign unused_bits = &{1'b0, stage_i.payload[31:16], s1_q.payload[31:23]};

endmodule

// File: rtl/float_conv_arbiter.sv
// Two-requester arbiter sharing one int16->f32 pipe, credit-guarded result FIFO.
// FLOAT_CONV_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module float_conv_arbiter
  import float_conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  float_conv_arbiter_if.slave  bus
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW:0]     DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  conv_stage_t           stage_in, stage_out;
  logic [INFLIGHT_W-1:0] in_flight;
  fifo_entry_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW:0]           occupancy;
  logic                  credit_ok, grant0, grant1, push, pop, empty;

  // Every accepted sample already owns a FIFO slot, so a push can never overflow.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(in_flight);
  assign credit_ok = occupancy < DEPTH_L;

`ifdef FLOAT_CONV_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (credit_ok && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant0) last_d = 1'b0;
    if (grant1) last_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (credit_ok && !reset) begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid && !bus.req0_valid;
    end
  end
`endif

  always_comb begin
    stage_in         = '0;
    stage_in.valid   = grant0 || grant1;
    stage_in.src     = grant1;
    stage_in.payload = {16'd0, grant1 ? bus.req1_data : bus.req0_data};
  end

  int16_to_f32_pipe u_pipe (
    .clk         (clk),
    .reset       (reset),
    .stage_i     (stage_in),
    .stage_o     (stage_out),
    .in_flight_o (in_flight)
  );

  assign push  = stage_out.valid;
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{src: stage_out.src, data: stage_out.payload};
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? FLOAT_ZERO : mem_q[rd_q].data;
  assign bus.out_src    = !empty && mem_q[rd_q].src;
  assign bus.busy       = (in_flight != '0) || !empty;

endmodule
